// File: rtl/hazard_forward_unit_pkg.sv
// rtl/hazard_forward_unit_pkg.sv - shared forward codes and pipeline slot type
package hazard_forward_unit_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } slot_t;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - ID-side inputs and pipeline control outputs
interface hazard_forward_unit_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  flush;

  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  stall;
  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_bubble;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    input  fwd_a, fwd_b, stall, pc_write, if_id_write, id_ex_bubble,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_reg_write, id_mem_read, flush,
    output fwd_a, fwd_b, stall, pc_write, if_id_write, id_ex_bubble,
           stall_count, flush_count
  );

endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// rtl/hazard_forward_unit_fwd_select.sv - operand forward-source comparator
module fwd_select
  import hazard_forward_unit_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  slot_t                 mem,
  input  slot_t                 wb,
  output logic [1:0]            code
);

  // Loads sitting in MEM have no data yet; the load-use stall pushes them to WB.
  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem.valid && mem.reg_write && !mem.mem_read &&
                   (mem.rd != '0) && (mem.rd == ex_rs);
  assign wb_hit  = wb.valid && wb.reg_write &&
                   (wb.rd != '0) && (wb.rd == ex_rs);

  always_comb begin
    code = FWD_REG;
    if (mem_hit) begin
      code = FWD_MEM;
    end else if (wb_hit) begin
      code = FWD_WB;
    end
  end

  logic unused_wb_mem_read;
  assign unused_wb_mem_read = wb.mem_read;

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX/MEM/WB shadow slots, forwarding and load-use stall
module hazard_forward_unit #(
  parameter int REG_ADDR_W = hazard_forward_unit_pkg::REG_ADDR_W,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_forward_unit_if.slave bus
);

  import hazard_forward_unit_pkg::*;

  slot_t                 ex_slot;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  slot_t                 mem_slot;
  slot_t                 wb_slot;

  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  logic [1:0]            code_a;
  logic [1:0]            code_b;
  logic                  load_use;
  logic                  stall;
  logic                  flush;
  logic                  ex_load;

  fwd_select u_fwd_a (
    .ex_rs (ex_rs1),
    .mem   (mem_slot),
    .wb    (wb_slot),
    .code  (code_a)
  );

  fwd_select u_fwd_b (
    .ex_rs (ex_rs2),
    .mem   (mem_slot),
    .wb    (wb_slot),
    .code  (code_b)
  );

  assign load_use = bus.id_valid && ex_slot.valid && ex_slot.mem_read &&
                    (ex_slot.rd != '0) &&
                    ((bus.id_use_rs1 && (bus.id_rs1 == ex_slot.rd)) ||
                     (bus.id_use_rs2 && (bus.id_rs2 == ex_slot.rd)));

  // A redirect kills the dependent instruction, so it never needs to wait.
  assign flush   = bus.flush && !reset;
  assign stall   = load_use && !bus.flush && !reset;
  assign ex_load = bus.id_valid && !stall && !bus.flush;

  assign bus.fwd_a        = reset ? FWD_REG : code_a;
  assign bus.fwd_b        = reset ? FWD_REG : code_b;
  assign bus.stall        = stall;
  assign bus.pc_write     = !stall;
  assign bus.if_id_write  = !stall;
  assign bus.id_ex_bubble = stall || flush;
  assign bus.stall_count  = stall_cnt;
  assign bus.flush_count  = flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_slot   <= '0;
      ex_rs1    <= '0;
      ex_rs2    <= '0;
      mem_slot  <= '0;
      wb_slot   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
      if (ex_load) begin
        ex_slot.valid     <= 1'b1;
        ex_slot.rd        <= bus.id_rd;
        ex_slot.reg_write <= bus.id_reg_write;
        ex_slot.mem_read  <= bus.id_mem_read;
        ex_rs1            <= bus.id_rs1;
        ex_rs2            <= bus.id_rs2;
      end else begin
        ex_slot <= '0;
        ex_rs1  <= '0;
        ex_rs2  <= '0;
      end
      if (stall) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  hazard_forward_unit_if bus ();

  hazard_forward_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic id(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                    input logic [4:0] rs2, input logic u1, input logic u2,
                    input logic rw, input logic mr);
    bus.id_valid     = v;
    bus.id_rd        = rd;
    bus.id_rs1       = rs1;
    bus.id_rs2       = rs2;
    bus.id_use_rs1   = u1;
    bus.id_use_rs2   = u2;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id(1'b1, rd, rs1, rs2, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic load(input logic [4:0] rd, input logic [4:0] rs1);
    id(1'b1, rd, rs1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic nop();
    id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic check_ctrl(input string tag, input logic st, input logic bub);
    check({tag, "_stall"}, bus.stall, st);
    check({tag, "_pc_write"}, bus.pc_write, !st);
    check({tag, "_if_id_write"}, bus.if_id_write, !st);
    check({tag, "_bubble"}, bus.id_ex_bubble, bub);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    bus.flush = 1'b0;
    nop();
    repeat (2) tick();
    check("rst_fwd_a", bus.fwd_a, 2'b00);
    check("rst_fwd_b", bus.fwd_b, 2'b00);
    check_ctrl("rst", 1'b0, 1'b0);
    check("rst_stall_count", bus.stall_count, 0);
    check("rst_flush_count", bus.flush_count, 0);
    reset = 1'b0;
    tick();

    // back-to-back ALU dependency: forward from MEM
    alu(5'd5, 5'd1, 5'd2); tick();
    alu(5'd6, 5'd5, 5'd1); tick();
    nop(); #1;
    check("t1_fwd_a", bus.fwd_a, 2'b10);
    check("t1_fwd_b", bus.fwd_b, 2'b00);
    check("t1_stall", bus.stall, 1'b0);
    drain();

    // one-gap dependency on rs2: forward from WB
    alu(5'd5, 5'd1, 5'd2); tick();
    nop(); tick();
    alu(5'd7, 5'd1, 5'd5); tick();
    nop(); #1;
    check("t2_fwd_a", bus.fwd_a, 2'b00);
    check("t2_fwd_b", bus.fwd_b, 2'b01);
    drain();

    // two producers of x5: the younger in MEM wins
    alu(5'd5, 5'd1, 5'd2); tick();
    alu(5'd5, 5'd3, 5'd4); tick();
    alu(5'd8, 5'd5, 5'd5); tick();
    nop(); #1;
    check("t3_fwd_a", bus.fwd_a, 2'b10);
    check("t3_fwd_b", bus.fwd_b, 2'b10);
    drain();

    // load-use: one stall cycle, then forward from WB
    load(5'd4, 5'd1); tick();
    alu(5'd9, 5'd4, 5'd2); #1;
    check_ctrl("t4_stall_cyc", 1'b1, 1'b1);
    tick();
    check_ctrl("t4_after", 1'b0, 1'b0);
    tick();
    nop(); #1;
    check("t4_fwd_a", bus.fwd_a, 2'b01);
    check("t4_fwd_b", bus.fwd_b, 2'b00);
    check("t4_stall_count", bus.stall_count, 1);
    drain();

    // load-use on rs2 only; rs1 match ignored when not read
    load(5'd4, 5'd1); tick();
    id(1'b1, 5'd10, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0); #1;
    check("t4b_rs2_stall", bus.stall, 1'b1);
    id(1'b1, 5'd10, 5'd4, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0); #1;
    check("t4b_no_use_stall", bus.stall, 1'b0);
    tick();
    nop(); #1;
    check("t4b_load_in_mem_fwd_a", bus.fwd_a, 2'b00);
    check("t4b_stall_count", bus.stall_count, 1);
    drain();

    // x0 never forwards, and a load to x0 never stalls
    id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    alu(5'd3, 5'd0, 5'd0); tick();
    nop(); #1;
    check("t5_fwd_a", bus.fwd_a, 2'b00);
    check("t5_fwd_b", bus.fwd_b, 2'b00);
    drain();
    load(5'd0, 5'd1); tick();
    alu(5'd1, 5'd0, 5'd0); #1;
    check("t5_lw_x0_stall", bus.stall, 1'b0);
    drain();

    // flush beats load-use; the flushed instruction never reaches EX
    load(5'd4, 5'd1); tick();
    alu(5'd11, 5'd4, 5'd2);
    bus.flush = 1'b1; #1;
    check_ctrl("t6_flush", 1'b0, 1'b1);
    tick();
    bus.flush = 1'b0;
    check("t6_flush_count", bus.flush_count, 1);
    check("t6_stall_count", bus.stall_count, 1);
    alu(5'd12, 5'd11, 5'd0); tick();
    nop(); #1;
    check("t6_killed_no_fwd", bus.fwd_a, 2'b00);
    drain();

    // reset during a live load-use stall
    load(5'd4, 5'd1); tick();
    alu(5'd9, 5'd4, 5'd2); #1;
    check("t7_pre_stall", bus.stall, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check_ctrl("t7_post_rst", 1'b0, 1'b0);
    check("t7_fwd_a", bus.fwd_a, 2'b00);
    check("t7_fwd_b", bus.fwd_b, 2'b00);
    check("t7_stall_count", bus.stall_count, 0);
    check("t7_flush_count", bus.flush_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Tracks destination-register metadata for the EX, MEM and WB slots of the 5-stage pipeline.
- Generates the 2-bit operand-select codes consumed by the EX-stage 4:1 operand muxes.
- Detects load-use hazards and drives stall and bubble control to PC, IF/ID and ID/EX.
- Sits between the ID decode logic and the EX operand muxes; owns its own shadow pipeline of rd/control bits.

Parameters:
- REG_ADDR_W, 5, register-index width.
- CNT_W, 32, width of the stall and flush performance counters.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  ID holds a real instruction
- id_rs1  input  REG_ADDR_W  ID source register 1
- id_rs2  input  REG_ADDR_W  ID source register 2
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_rd  input  REG_ADDR_W  ID destination register
- id_reg_write  input  1  ID instruction writes rd
- id_mem_read  input  1  ID instruction is a load
- flush  input  1  EX-resolved redirect; kills the ID instruction
- fwd_a  output  2  select for EX operand A mux
- fwd_b  output  2  select for EX operand B mux
- stall  output  1  load-use stall
- pc_write  output  1  PC update enable
- if_id_write  output  1  IF/ID register enable
- id_ex_bubble  output  1  ID/EX register loads a NOP
- stall_count  output  CNT_W  number of stall cycles
- flush_count  output  CNT_W  number of flush cycles

Behaviour:
- Slot registers: ex_{valid,rs1,rs2,rd,reg_write,mem_read}; mem_{valid,rd,reg_write,mem_read}; wb_{valid,rd,reg_write}.
- Reset (synchronous): all slot valid/reg_write/mem_read bits = 0; rd/rs fields = 0; both counters = 0.
- Reset outputs: fwd_a = fwd_b = 2'b00, stall = 0, pc_write = 1, if_id_write = 1, id_ex_bubble = 0.
- Slot advance each posedge when not in reset:
  - mem <= ex; wb <= mem.
  - ex <= ID fields when id_valid & !stall & !flush.
  - Otherwise ex <= bubble (valid = 0, reg_write = 0, mem_read = 0).
- Forward codes (combinational from slot registers):
  - 2'b10 = MEM-stage ALU result.
  - 2'b01 = WB writeback data.
  - 2'b00 = register-file value.
  - 2'b11 is never driven.
- fwd_a conditions:
  - 2'b10 if mem_valid & mem_reg_write & !mem_mem_read & mem_rd != 0 & mem_rd == ex_rs1.
  - Else 2'b01 if wb_valid & wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1.
  - Else 2'b00.
- fwd_b: same rules against ex_rs2.
- Priority: MEM beats WB when both match (youngest producer wins).
- Loads in MEM are never forwarded from MEM; the load-use stall guarantees they reach WB first.
- x0: rd == 0 never forwards, even with reg_write = 1.
- Load-use stall (combinational): stall = id_valid & ex_valid & ex_mem_read & ex_rd != 0 & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)) & !flush.
- During stall: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
- Stall lasts exactly 1 cycle per load-use pair; the bubble clears the condition on the next cycle.
- Flush: id_ex_bubble = 1, pc_write = 1, if_id_write = 1; the ID instruction does not enter ex.
- Simultaneous flush and stall condition: flush wins, stall = 0.
- Counters: stall_count += 1 on each stall cycle; flush_count += 1 on each flush cycle; both wrap modulo 2^CNT_W.
- Reset asserted mid-stall: next cycle all slots empty, stall = 0.
- Latency: forward codes are valid in the same cycle the consumer is in EX; there are no registered outputs except the counters.

Decomposition:
- Shared package holds:
  - FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
  - REG_ADDR_W default.
  - Slot struct typedef {valid, rd, reg_write, mem_read}.
- One sub-module, fwd_select: a pure combinational comparator instantiated twice (operand A and operand B), taking ex_rs, mem slot and wb slot and returning the 2-bit code.

Test Plan:
- add x5 then add x6,x5,x1 back-to-back -> cycle the second add is in EX: fwd_a = 2'b10, fwd_b = 2'b00, stall = 0.
- add x5; nop; sub x7,x1,x5 -> sub in EX: fwd_b = 2'b01, fwd_a = 2'b00.
- add x5,...; add x5,...; or x8,x5,x5 -> fwd_a = fwd_b = 2'b10 (MEM priority over WB).
- lw x4; add x9,x4,x2 -> one cycle with stall = 1, pc_write = 0, if_id_write = 0, id_ex_bubble = 1. Next cycle stall = 0 and add in EX has fwd_a = 2'b01. stall_count = 1.
- addi x0,x0,1 followed by add x3,x0,x0 -> fwd_a = fwd_b = 2'b00. Also lw x0 followed by a consumer of x0 -> no stall.
- Load-use condition with flush = 1 in the same cycle -> stall = 0, id_ex_bubble = 1, flush_count increments, stall_count unchanged. Reset pulse afterward -> all outputs at reset values on the next cycle.
